// File: rtl/relu_stream_serializer_if.sv
// Handshake bundle for relu_stream_serializer: a flattened feature map in, ReLU'd elements
// with coordinates out. The master side drives the map and downstream ready.
interface relu_stream_serializer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int H          = 10,
    parameter int W          = 10,
    parameter int CHANNEL    = 16
);
    localparam int N     = H * W * CHANNEL;
    localparam int CH_W  = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
    localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
    localparam int COL_W = (W > 1) ? $clog2(W) : 1;
    localparam int ZC_W  = $clog2(N + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] in_map;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [CH_W-1:0]         out_ch;
    logic [ROW_W-1:0]        out_row;
    logic [COL_W-1:0]        out_col;
    logic                    out_last;
    logic [ZC_W-1:0]         zero_count;
    logic                    done;

    modport master (
        output in_valid, in_map, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_row, out_col,
               out_last, zero_count, done
    );

    modport slave (
        input  in_valid, in_map, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_row, out_col,
               out_last, zero_count, done
    );
endinterface

// File: rtl/relu_stream_serializer.sv
// Latches a whole feature map, then streams ReLU'd elements one per accepted beat (first beat the
// cycle after acceptance); out_ready=0 holds the current element, and no map is taken while streaming.
module relu_stream_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int H          = 10,
    parameter int W          = 10,
    parameter int CHANNEL    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    relu_stream_serializer_if.slave bus
);
    localparam int N     = H * W * CHANNEL;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CH_W  = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
    localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
    localparam int COL_W = (W > 1) ? $clog2(W) : 1;
    localparam int ZC_W  = $clog2(N + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(W - 1);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                           state_q, state_d;
    logic [N-1:0][DATA_WIDTH-1:0]     buf_q, buf_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [CH_W-1:0]                  ch_q, ch_d;
    logic [ROW_W-1:0]                 row_q, row_d;
    logic [COL_W-1:0]                 col_q, col_d;
    logic [ZC_W-1:0]                  run_cnt_q, run_cnt_d;
    logic [ZC_W-1:0]                  zero_count_q, zero_count_d;
    logic                             done_q, done_d;

    logic [DATA_WIDTH-1:0]            cur_elem;
    logic                             cur_neg;
    logic                             at_last;
    logic [ZC_W-1:0]                  run_inc;

    assign cur_elem = buf_q[idx_q];
    // Any sign-set pattern clamps, including -0, -inf and negative NaN.
    assign cur_neg  = cur_elem[DATA_WIDTH-1];
    assign at_last  = (idx_q == IDX_LAST);
    assign run_inc  = run_cnt_q + ZC_W'(cur_neg);

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        idx_d        = idx_q;
        ch_d         = ch_q;
        row_d        = row_q;
        col_d        = col_q;
        run_cnt_d    = run_cnt_q;
        zero_count_d = zero_count_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    buf_d     = bus.in_map;
                    idx_d     = '0;
                    ch_d      = '0;
                    row_d     = '0;
                    col_d     = '0;
                    run_cnt_d = '0;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    if (at_last) begin
                        // Counters stay parked on the final coordinate until the next map loads.
                        zero_count_d = run_inc;
                        done_d       = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        run_cnt_d = run_inc;
                        idx_d     = idx_q + IDX_W'(1);
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                row_d = '0;
                                ch_d  = ch_q + CH_W'(1);
                            end else begin
                                row_d = row_q + ROW_W'(1);
                            end
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ch_q         <= '0;
            row_q        <= '0;
            col_q        <= '0;
            run_cnt_q    <= '0;
            zero_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ch_q         <= ch_d;
            row_q        <= row_d;
            col_q        <= col_d;
            run_cnt_q    <= run_cnt_d;
            zero_count_q <= zero_count_d;
            done_q       <= done_d;
        end
    end

    // Map storage carries no reset; its contents are only read while STREAM.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == STREAM);
    assign bus.out_data   = cur_neg ? '0 : cur_elem;
    assign bus.out_ch     = ch_q;
    assign bus.out_row    = row_q;
    assign bus.out_col    = col_q;
    assign bus.out_last   = (state_q == STREAM) && at_last;
    assign bus.zero_count = zero_count_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_relu_stream_serializer.sv
// Bench for relu_stream_serializer: 2x2x1, default 10x10x16 and 1x1x1 instances checked against
// an index/division based reference of the ReLU stream.
module tb_relu_stream_serializer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    relu_stream_serializer_if #(.DATA_WIDTH(16), .H(2), .W(2), .CHANNEL(1)) sif ();
    relu_stream_serializer_if #(.DATA_WIDTH(16), .H(10), .W(10), .CHANNEL(16)) dif ();
    relu_stream_serializer_if #(.DATA_WIDTH(16), .H(1), .W(1), .CHANNEL(1)) oif ();

    relu_stream_serializer #(.DATA_WIDTH(16), .H(2), .W(2), .CHANNEL(1)) u_small (
        .clk(clk), .reset(reset), .bus(sif.slave));
    relu_stream_serializer #(.DATA_WIDTH(16), .H(10), .W(10), .CHANNEL(16)) u_dflt (
        .clk(clk), .reset(reset), .bus(dif.slave));
    relu_stream_serializer #(.DATA_WIDTH(16), .H(1), .W(1), .CHANNEL(1)) u_one (
        .clk(clk), .reset(reset), .bus(oif.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] relu_ref(input logic [15:0] e);
        return e[15] ? 16'h0000 : e;
    endfunction

    task automatic offer_small(input logic [63:0] map);
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_map   = map;
    endtask

    // Called with a map already offered for the coming edge; streams it and checks the done beat.
    task automatic drain_small(input logic [63:0] map, input int mode,
                               input bit hold_valid, input logic [63:0] next_map);
        int         i;
        int         k;
        int         zc;
        bit         rdy;
        logic [15:0] e;
        i  = 0;
        k  = 0;
        zc = 0;
        for (int j = 0; j < 4; j++) begin
            e = map[j*16 +: 16];
            if (e[15]) zc++;
        end
        @(negedge clk);
        sif.in_valid = hold_valid;
        sif.in_map   = next_map;
        while (i < 4) begin
            if (k >= 100) begin
                checks++; errors++;
                $display("FAIL small_timeout idx=%0d after %0d cycles, want 4 elements", i, k);
                break;
            end
            e = map[i*16 +: 16];
            checks++;
            if (sif.out_valid !== 1'b1 || sif.in_ready !== 1'b0 || sif.done !== 1'b0) begin
                errors++;
                $display("FAIL small_ctrl idx=%0d valid=%b in_ready=%b done=%b, want 1 0 0",
                         i, sif.out_valid, sif.in_ready, sif.done);
            end
            checks++;
            if (sif.out_data !== relu_ref(e)) begin
                errors++;
                $display("FAIL small_data idx=%0d got %h want %h", i, sif.out_data, relu_ref(e));
            end
            checks++;
            if (sif.out_col !== 1'(i % 2) || sif.out_row !== 1'((i / 2) % 2) ||
                sif.out_ch !== 1'(i / 4) || sif.out_last !== (i == 3)) begin
                errors++;
                $display("FAIL small_coord idx=%0d got ch%0d r%0d c%0d last%b want ch%0d r%0d c%0d last%b",
                         i, sif.out_ch, sif.out_row, sif.out_col, sif.out_last,
                         i / 4, (i / 2) % 2, i % 2, i == 3);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            sif.out_ready = rdy;
            if (rdy) i++;
            k++;
            @(negedge clk);
        end
        checks++;
        if (sif.done !== 1'b1 || sif.out_valid !== 1'b0 || sif.in_ready !== 1'b1 ||
            sif.zero_count !== 3'(zc)) begin
            errors++;
            $display("FAIL small_done done=%b valid=%b in_ready=%b zc=%0d, want 1 0 1 zc=%0d",
                     sif.done, sif.out_valid, sif.in_ready, sif.zero_count, zc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (sif.in_ready !== 1'b1 || sif.out_valid !== 1'b0 || sif.out_last !== 1'b0 ||
            sif.done !== 1'b0 || sif.zero_count !== 3'd0 || sif.out_ch !== 1'b0 ||
            sif.out_row !== 1'b0 || sif.out_col !== 1'b0) begin
            errors++;
            $display("FAIL reset_small rdy=%b vld=%b last=%b done=%b zc=%0d ch%0d r%0d c%0d, want 1 0 0 0 0 0 0 0",
                     sif.in_ready, sif.out_valid, sif.out_last, sif.done, sif.zero_count,
                     sif.out_ch, sif.out_row, sif.out_col);
        end
        checks++;
        if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 || dif.done !== 1'b0 ||
            dif.zero_count !== 11'd0 || dif.out_ch !== 4'd0 || dif.out_row !== 4'd0 ||
            dif.out_col !== 4'd0) begin
            errors++;
            $display("FAIL reset_default rdy=%b vld=%b done=%b zc=%0d, want 1 0 0 0",
                     dif.in_ready, dif.out_valid, dif.done, dif.zero_count);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (oif.in_ready !== 1'b1 || oif.out_valid !== 1'b0 || oif.done !== 1'b0 ||
            oif.zero_count !== 1'b0) begin
            errors++;
            $display("FAIL reset_single rdy=%b vld=%b done=%b zc=%0d, want 1 0 0 0",
                     oif.in_ready, oif.out_valid, oif.done, oif.zero_count);
        end
    endtask

    task automatic test_basic();
        logic [63:0] map;
        map = {16'h7BFF, 16'h8000, 16'hBC00, 16'h3C00};
        offer_small(map);
        drain_small(map, 0, 1'b0, 64'h0);
        @(negedge clk);
        checks++;
        if (sif.done !== 1'b0 || sif.zero_count !== 3'd2) begin
            errors++;
            $display("FAIL basic_hold done=%b zc=%0d, want 0 2", sif.done, sif.zero_count);
        end
    endtask

    task automatic test_stall();
        logic [63:0] map;
        map = {16'h7BFF, 16'h8000, 16'hBC00, 16'h3C00};
        offer_small(map);
        drain_small(map, 1, 1'b0, {$urandom, $urandom});
    endtask

    task automatic test_nan();
        logic [63:0] map;
        map = {16'($urandom), 16'($urandom), 16'h7E00, 16'hFE00};
        offer_small(map);
        drain_small(map, 2, 1'b0, 64'h0);
    endtask

    task automatic test_random();
        logic [63:0] map;
        logic [2:0]  zc_seen;
        for (int m = 0; m < 6; m++) begin
            map = {$urandom, $urandom};
            offer_small(map);
            drain_small(map, 2, 1'b0, {$urandom, $urandom});
            zc_seen = sif.zero_count;
            repeat (3) @(negedge clk);
            checks++;
            if (sif.zero_count !== zc_seen || sif.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL random_idle_hold zc=%0d valid=%b, want zc=%0d valid=0",
                         sif.zero_count, sif.out_valid, zc_seen);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] map_a;
        logic [63:0] map_b;
        map_a = {$urandom, $urandom};
        map_b = {$urandom, $urandom};
        offer_small(map_a);
        drain_small(map_a, 0, 1'b1, map_b);
        drain_small(map_b, 2, 1'b0, {$urandom, $urandom});
    endtask

    task automatic test_reset_mid();
        logic [63:0] map;
        map = {16'h8001, 16'hFFFF, 16'h8000, 16'hC000};
        offer_small(map);
        @(negedge clk);
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (sif.out_valid !== 1'b1 || sif.out_col !== 1'b0 || sif.out_row !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre valid=%b r%0d c%0d, want 1 r1 c0",
                     sif.out_valid, sif.out_row, sif.out_col);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (sif.out_valid !== 1'b0 || sif.out_last !== 1'b0 || sif.in_ready !== 1'b1 ||
            sif.zero_count !== 3'd0 || sif.done !== 1'b0) begin
            errors++;
            $display("FAIL mid_async valid=%b last=%b rdy=%b zc=%0d done=%b, want 0 0 1 0 0",
                     sif.out_valid, sif.out_last, sif.in_ready, sif.zero_count, sif.done);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (sif.done !== 1'b0 || sif.out_valid !== 1'b0 || sif.zero_count !== 3'd0) begin
                errors++;
                $display("FAIL mid_after done=%b valid=%b zc=%0d, want 0 0 0",
                         sif.done, sif.out_valid, sif.zero_count);
            end
        end
        map = {$urandom, $urandom};
        offer_small(map);
        drain_small(map, 2, 1'b0, 64'h0);
    endtask

    task automatic test_single();
        logic [15:0] e;
        oif.out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            e = 16'($urandom);
            e[15] = m[0];
            @(negedge clk);
            oif.in_valid = 1'b1;
            oif.in_map   = e;
            @(negedge clk);
            oif.in_valid = 1'b0;
            checks++;
            if (oif.out_valid !== 1'b1 || oif.out_last !== 1'b1 || oif.out_data !== relu_ref(e) ||
                oif.out_ch !== 1'b0 || oif.out_row !== 1'b0 || oif.out_col !== 1'b0) begin
                errors++;
                $display("FAIL single_elem valid=%b last=%b data=%h, want 1 1 %h",
                         oif.out_valid, oif.out_last, oif.out_data, relu_ref(e));
            end
            @(negedge clk);
            checks++;
            if (oif.done !== 1'b1 || oif.out_valid !== 1'b0 || oif.zero_count !== e[15]) begin
                errors++;
                $display("FAIL single_done done=%b valid=%b zc=%0d, want 1 0 %0d",
                         oif.done, oif.out_valid, oif.zero_count, e[15]);
            end
        end
    endtask

    task automatic test_default();
        logic [1600*16-1:0] dmap;
        logic [15:0]        e;
        int                 zc;
        int                 i;
        int                 k;
        bit                 rdy;
        for (int m = 0; m < 2; m++) begin
            zc = 0;
            for (int j = 0; j < 1600; j++) begin
                e = (m == 0) ? 16'hC000 : 16'($urandom);
                dmap[j*16 +: 16] = e;
                if (e[15]) zc++;
            end
            @(negedge clk);
            dif.in_valid = 1'b1;
            dif.in_map   = dmap;
            @(negedge clk);
            dif.in_valid = 1'b0;
            i = 0;
            k = 0;
            while (i < 1600) begin
                if (k >= 20000) begin
                    checks++; errors++;
                    $display("FAIL default_timeout map%0d idx=%0d, want 1600 elements", m, i);
                    break;
                end
                e = dmap[i*16 +: 16];
                checks++;
                if (dif.out_valid !== 1'b1 || dif.out_data !== relu_ref(e) ||
                    dif.out_col !== 4'(i % 10) || dif.out_row !== 4'((i / 10) % 10) ||
                    dif.out_ch !== 4'(i / 100) || dif.out_last !== (i == 1599)) begin
                    errors++;
                    $display("FAIL default_elem map%0d idx=%0d got %h ch%0d r%0d c%0d last%b want %h ch%0d r%0d c%0d last%b",
                             m, i, dif.out_data, dif.out_ch, dif.out_row, dif.out_col, dif.out_last,
                             relu_ref(e), i / 100, (i / 10) % 10, i % 10, i == 1599);
                end
                rdy = (m == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                dif.out_ready = rdy;
                if (rdy) i++;
                k++;
                @(negedge clk);
            end
            checks++;
            if (dif.done !== 1'b1 || dif.out_valid !== 1'b0 || dif.zero_count !== 11'(zc)) begin
                errors++;
                $display("FAIL default_done map%0d done=%b valid=%b zc=%0d, want 1 0 %0d",
                         m, dif.done, dif.out_valid, dif.zero_count, zc);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        sif.in_valid  = 1'b0;
        sif.in_map    = '0;
        sif.out_ready = 1'b0;
        dif.in_valid  = 1'b0;
        dif.in_map    = '0;
        dif.out_ready = 1'b0;
        oif.in_valid  = 1'b0;
        oif.in_map    = '0;
        oif.out_ready = 1'b0;

        test_reset();
        test_basic();
        test_stall();
        test_nan();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_single();
        test_default();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/relu_stream_serializer.md
RELU_STREAM_SERIALIZER -- requirements
Module: relu_stream_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the FP16 element width.
REQ-002 SHALL have parameter H, default 10, the feature-map height.
REQ-003 SHALL have parameter W, default 10, the feature-map width.
REQ-004 SHALL have parameter CHANNEL, default 16, the feature-map channel count; N = H*W*CHANNEL elements.
REQ-005 SHALL have port clk, input, 1 bit: the only clock, rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: a flattened feature map is offered.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a feature map.
REQ-009 SHALL have port in_map, input, N*DATA_WIDTH bits: element i sits at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a valid element.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-012 SHALL have port out_data, output, DATA_WIDTH bits: the ReLU'd element.
REQ-013 SHALL have port out_ch, out_row, out_col, outputs, each $clog2 of CHANNEL/H/W (minimum 1) bits: coordinates of out_data.
REQ-014 SHALL have port out_last, output, 1 bit: out_data is element N-1.
REQ-015 SHALL have port zero_count, output, $clog2(N+1) bits: number of clamped elements in the last completed map.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when a map completes.

Function
REQ-017 SHALL implement two states, IDLE and STREAM.
REQ-018 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-019 A transfer SHALL occur on a clk edge where in_valid=1 and in_ready=1; in_map is latched into an internal buffer, the index is set to 0, the running zero counter is cleared, and the state becomes STREAM.
REQ-020 In STREAM, in_ready SHALL be 0, and in_map changes SHALL have no effect.
REQ-021 In STREAM, out_valid SHALL be 1.
REQ-022 In STREAM, out_data SHALL be 0 when the sign bit (bit DATA_WIDTH-1) of buffered element idx is 1, including -0, negative infinity and sign-set NaN; otherwise out_data SHALL equal the buffered element bit-exactly.
REQ-023 out_data SHALL be combinational from the buffer and idx; the first element is valid the cycle after input acceptance.
REQ-024 Element order SHALL be idx = 0..N-1, with out_col = idx mod W, out_row = (idx/W) mod H, out_ch = idx/(H*W); coordinates SHALL be maintained as counters with nested wrap (col wraps to 0 and increments row; row wraps to 0 and increments ch), not by division.
REQ-025 The index SHALL advance only on out_valid=1 and out_ready=1.
REQ-026 While out_ready=0, out_data and all coordinate outputs SHALL hold stable.
REQ-027 out_last SHALL be 1 exactly when idx = N-1 in STREAM.
REQ-028 The running zero counter SHALL increment on each accepted element whose sign bit is 1.
REQ-029 On acceptance of the last element, the block SHALL load zero_count with the final count (including the last element), pulse done for that one following cycle, and return to IDLE.
REQ-030 A new map SHALL NOT be accepted in the same cycle as the last output; the earliest acceptance is the cycle done is high.
REQ-031 zero_count SHALL hold its value until the next map completes.
REQ-032 With N=1, a map SHALL stream a single element with out_last=1.

Reset
REQ-033 While reset=1, state SHALL be IDLE; idx, coordinates, counters and zero_count SHALL be 0; done, out_valid and out_last SHALL be 0; and in_ready SHALL be 1. The buffer contents are don't-care.
REQ-034 Reset asserted mid-STREAM SHALL abort the map immediately without a done pulse, and the partial count SHALL be discarded.

Verification
REQ-035 Map with H=W=2, CHANNEL=1, and elements {0x3C00, 0xBC00, 0x8000, 0x7BFF}, out_ready held at 1 -> outputs 3C00, 0000, 0000, 7BFF on consecutive cycles, out_last on the 4th, done the next cycle, zero_count=2.
REQ-036 Same map with out_ready toggling 1,0,0,1,... -> identical output sequence, and values and coordinates stable during stalls.
REQ-037 Default parameters, all elements 0xC000 -> 1600 zero outputs, coordinates ending at ch=15, row=9, col=9, and zero_count=1600.
REQ-038 in_valid held at 1 with different maps back-to-back -> second map accepted on the done cycle, and no element lost or duplicated.
REQ-039 Reset pulsed after 2 of 4 elements -> out_valid drops asynchronously, no done pulse, zero_count=0, and the next map streams from idx 0.
REQ-040 Elements 0xFE00 (negative NaN) and 0x7E00 (positive NaN) -> out_data 0x0000 and 0x7E00 respectively.
